systolic_mac_array: RTL and testbench

Parametrised output-stationary N×N systolic matrix-multiply engine. It computes C = A·B, where A is N×K and B is K×N, with K set per job at run time. A is streamed one column per beat and B one row per beat over a valid/ready input port. Input skew is generated internally, and results are drained one row of C per handshake. It generalises the fixed 5-lane byte-wide systolic top to configurable size, width, signedness and job length, with flow control on both sides.

---
 rtl/systolic_mac_array.sv | 245 ++++++++++++++++++++++++
 tb/tb_systolic_mac_array.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mac_array.sv
// Output-stationary N x N systolic matrix-multiply engine computing C = A * B.
// A streams in one column per beat and B one row per beat. Both are skewed
// internally so that A[i][k] and B[k][j] meet in PE(i,j). The finished C is
// drained one row per out_valid/out_ready handshake.
//
// Handshakes: a beat transfers on a rising edge where a_valid && a_ready.
// A result row transfers on a rising edge where out_valid && out_ready.
// Nothing transfers while ena is low.
module systolic_mac_array #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int K_W    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          start,
    input  logic [K_W-1:0]                k_len,
    input  logic                          signed_mode,
    input  logic                          a_valid,
    output logic                          a_ready,
    input  logic [N*DATA_W-1:0]           a_data,
    input  logic [N*DATA_W-1:0]           b_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [((N>1)?$clog2(N):1)-1:0] out_row,
    output logic [N*ACC_W-1:0]            out_data,
    output logic                          busy,
    output logic                          done
);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(2 * N) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    // Control state. state_q is kept as a plain named register for probing.
    state_t           state_q;
    logic [K_W-1:0]   k_q;
    logic             sm_q;
    logic [K_W-1:0]   beat_q;
    logic [CNT_W-1:0] flush_q;
    logic [ROW_W-1:0] row_q;
    logic             a_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;

    // Skew lines. Stage 0 captures the beat, and lane i leaves from stage i.
    logic [DATA_W-1:0] ska_q  [N][N];
    logic              skav_q [N][N];
    logic [DATA_W-1:0] skb_q  [N][N];
    logic              skbv_q [N][N];

    // PE registers: forwarded operands with their valid bits, and the accumulator.
    logic [DATA_W-1:0] pa_q  [N][N];
    logic              pav_q [N][N];
    logic [DATA_W-1:0] pb_q  [N][N];
    logic              pbv_q [N][N];
    logic [ACC_W-1:0]  acc_q [N][N];

    // Operands seen by each PE this cycle.
    logic [DATA_W-1:0] a_in  [N][N];
    logic              av_in [N][N];
    logic [DATA_W-1:0] b_in  [N][N];
    logic              bv_in [N][N];

    logic push;
    logic clr;

    assign push = (state_q == S_FEED) && a_valid;
    assign clr  = (state_q == S_IDLE) && start;

    // Full-width product: the low 2*DATA_W bits of the extended operands' product
    // form the exact product, which is then extended to the accumulator width.
    function automatic logic [ACC_W-1:0] mac_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              sm);
        logic [2*DATA_W-1:0] ae;
        logic [2*DATA_W-1:0] be;
        logic [2*DATA_W-1:0] p;
        ae = sm ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        be = sm ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        p  = ae * be;
        mac_ext = ACC_W'(p);
        if (sm) mac_ext = ACC_W'($signed(p));
        return mac_ext;
    endfunction

    // Job sequencing: IDLE -> FEED -> FLUSH -> DRAIN -> IDLE. All outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            sm_q        <= 1'b0;
            beat_q      <= '0;
            flush_q     <= '0;
            row_q       <= '0;
            a_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (ena) begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            k_q     <= k_len;
                            sm_q    <= signed_mode;
                            beat_q  <= '0;
                            flush_q <= '0;
                            row_q   <= '0;
                            busy_q  <= 1'b1;
                            if (k_len != '0) begin
                                state_q   <= S_FEED;
                                a_ready_q <= 1'b1;
                            end else begin
                                state_q     <= S_DRAIN;
                                out_valid_q <= 1'b1;
                            end
                        end
                    end
                    S_FEED: begin
                        if (a_valid) begin
                            beat_q <= beat_q + K_W'(1);
                            if (beat_q + K_W'(1) == k_q) begin
                                state_q   <= S_FLUSH;
                                a_ready_q <= 1'b0;
                            end
                        end
                    end
                    S_FLUSH: begin
                        // The last beat reaches PE(N-1,N-1) after 2N-1 bubbles.
                        if (flush_q == CNT_W'(2 * N - 2)) begin
                            state_q     <= S_DRAIN;
                            out_valid_q <= 1'b1;
                        end else begin
                            flush_q <= flush_q + CNT_W'(1);
                        end
                    end
                    S_DRAIN: begin
                        if (out_ready) begin
                            if (row_q == ROW_W'(N - 1)) begin
                                state_q     <= S_IDLE;
                                out_valid_q <= 1'b0;
                                busy_q      <= 1'b0;
                                done_q      <= 1'b1;
                                row_q       <= '0;
                            end else begin
                                row_q <= row_q + ROW_W'(1);
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Wire each PE's inputs from the array edge (skew output) or from its left and upper neighbours.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_in[i][0]  = ska_q[i][i];
            av_in[i][0] = skav_q[i][i];
            for (int j = 1; j < N; j++) begin
                a_in[i][j]  = pa_q[i][j-1];
                av_in[i][j] = pav_q[i][j-1];
            end
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j]  = skb_q[j][j];
            bv_in[0][j] = skbv_q[j][j];
            for (int i = 1; i < N; i++) begin
                b_in[i][j]  = pb_q[i-1][j];
                bv_in[i][j] = pbv_q[i-1][j];
            end
        end
    end

    // Skew lines and the PE grid. Outside accepted beats, invalid zero bubbles enter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ska_q[i][j]  <= '0;
                    skav_q[i][j] <= 1'b0;
                    skb_q[i][j]  <= '0;
                    skbv_q[i][j] <= 1'b0;
                    pa_q[i][j]   <= '0;
                    pav_q[i][j]  <= 1'b0;
                    pb_q[i][j]   <= '0;
                    pbv_q[i][j]  <= 1'b0;
                    acc_q[i][j]  <= '0;
                end
            end
        end else if (ena) begin
            for (int i = 0; i < N; i++) begin
                ska_q[i][0]  <= push ? a_data[i*DATA_W +: DATA_W] : '0;
                skav_q[i][0] <= push;
                skb_q[i][0]  <= push ? b_data[i*DATA_W +: DATA_W] : '0;
                skbv_q[i][0] <= push;
                for (int s = 1; s < N; s++) begin
                    ska_q[i][s]  <= ska_q[i][s-1];
                    skav_q[i][s] <= skav_q[i][s-1];
                    skb_q[i][s]  <= skb_q[i][s-1];
                    skbv_q[i][s] <= skbv_q[i][s-1];
                end
            end
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pa_q[i][j]  <= a_in[i][j];
                    pav_q[i][j] <= av_in[i][j];
                    pb_q[i][j]  <= b_in[i][j];
                    pbv_q[i][j] <= bv_in[i][j];
                    if (clr) begin
                        acc_q[i][j] <= '0;
                    end else if (av_in[i][j] && bv_in[i][j]) begin
                        acc_q[i][j] <= acc_q[i][j] + mac_ext(a_in[i][j], b_in[i][j], sm_q);
                    end
                end
            end
        end
    end

    // The presented row is read straight from the accumulators, which are frozen during DRAIN.
    always_comb begin
        out_data = '0;
        for (int j = 0; j < N; j++) begin
            out_data[j*ACC_W +: ACC_W] = acc_q[row_q][j];
        end
    end

    assign a_ready   = a_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array with the default N=4, 8-bit operands and 20-bit accumulators.
module tb_systolic_mac_array;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 20;
  localparam int KW = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ena;
  logic            start;
  logic [KW-1:0]   k_len;
  logic            signed_mode;
  logic            a_valid;
  logic            a_ready;
  logic [N*DW-1:0] a_data;
  logic [N*DW-1:0] b_data;
  logic            out_valid;
  logic            out_ready;
  logic [1:0]      out_row;
  logic [N*AW-1:0] out_data;
  logic            busy;
  logic            done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // A[i][k], B[k][j] and the hand-computed C for the current job
  logic [DW-1:0] amat  [N][32];
  logic [DW-1:0] bmat  [32][N];
  logic [AW-1:0] exp_c [N][N];

  systolic_mac_array #(.N(N), .DATA_W(DW), .ACC_W(AW), .K_W(KW)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .k_len(k_len),
    .signed_mode(signed_mode), .a_valid(a_valid), .a_ready(a_ready),
    .a_data(a_data), .b_data(b_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_row(out_row), .out_data(out_data),
    .busy(busy), .done(done)
  );

  // clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // advance one cycle; inputs are driven and outputs sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_identity();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 32; k++)
        amat[i][k] = (i == k) ? 8'd1 : 8'd0;
    for (int k = 0; k < 32; k++)
      for (int j = 0; j < N; j++)
        bmat[k][j] = (k < N) ? DW'(4 * k + j + 1) : 8'd0;
    // C = I * B = B : rows [1 2 3 4] [5 6 7 8] [9 10 11 12] [13 14 15 16]
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = AW'(4 * i + j + 1);
  endtask

  task automatic load_const(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [AW-1:0] cv);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 32; k++) begin
        amat[i][k] = av;
        bmat[k][i] = bv;
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_c[i][j] = cv;
  endtask

  // Runs one job from the start cycle up to the cycle in which done should be high.
  task automatic run_job(input int k, input bit sm, input bit gaps, input bit stall_flush,
                         input bit stall_drain, input bit poke_drain);
    int beat;
    int t_last;
    int guard;
    int n;
    int row;
    int stall_cnt;
    int exp_lat;
    logic [N*AW-1:0] ev;
    beat = 0; guard = 0; row = 0; stall_cnt = 0;
    k_len = KW'(k);
    signed_mode = sm;
    start = 1'b1;
    t_last = cyc;
    step();
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      begin n_errors++; $display("FAIL busy_after_start: busy=%b done=%b, want busy=1 done=0", busy, done); end
    n_checks++;
    if (a_ready !== (k != 0))
      begin n_errors++; $display("FAIL a_ready_after_start: got %b want %b", a_ready, (k != 0)); end
    // feed beats
    while (beat < k && guard < 200) begin
      a_valid = !(gaps && (guard % 2 == 1));
      for (int i = 0; i < N; i++) begin
        a_data[i*DW +: DW] = amat[i][beat];
        b_data[i*DW +: DW] = bmat[beat][i];
      end
      if (a_valid && a_ready) begin
        beat++;
        t_last = cyc;
      end
      step();
      guard++;
    end
    a_valid = 1'b0;
    n_checks++;
    if (beat < k)
      begin n_errors++; $display("FAIL feed_timeout: accepted %0d beats, want %0d", beat, k); end
    // flush, optionally with a 3-cycle clock-enable stall
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      n_checks++;
      if (a_ready !== 1'b0 || done !== 1'b0)
        begin n_errors++; $display("FAIL flush_flags: a_ready=%b done=%b, want 0 0", a_ready, done); end
      if (stall_flush && n == 2) begin
        ena = 1'b0;
        step(); step(); step();
        ena = 1'b1;
      end else begin
        step();
      end
      n++;
    end
    exp_lat = (k == 0) ? 1 : (stall_flush ? 11 : 8);
    n_checks++;
    if (cyc - t_last != exp_lat)
      begin n_errors++; $display("FAIL latency: got %0d cycles want %0d", cyc - t_last, exp_lat); end
    // drain
    guard = 0;
    while (row < N && guard < 100) begin
      out_ready = !(stall_drain && row == 2 && stall_cnt < 5);
      start = poke_drain && row == 1;
      a_valid = poke_drain;
      if (poke_drain) begin
        a_data = '1;
        b_data = '1;
      end
      for (int j = 0; j < N; j++) ev[j*AW +: AW] = exp_c[row][j];
      n_checks++;
      if (out_valid !== 1'b1 || out_row !== 2'(row) || out_data !== ev)
        begin n_errors++; $display("FAIL row%0d: valid=%b row=%0d data=%h want valid=1 row=%0d data=%h", row, out_valid, out_row, out_data, row, ev); end
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b1 || a_ready !== 1'b0)
        begin n_errors++; $display("FAIL drain_flags: done=%b busy=%b a_ready=%b want 0 1 0", done, busy, a_ready); end
      if (!out_ready) stall_cnt++;
      else row++;
      step();
      guard++;
    end
    start = 1'b0;
    a_valid = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (row < N)
      begin n_errors++; $display("FAIL drain_timeout: drained %0d rows want %0d", row, N); end
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
      begin n_errors++; $display("FAIL done_cycle: done=%b busy=%b out_valid=%b want 1 0 0", done, busy, out_valid); end
  endtask

  task automatic check_idle_after(input string name);
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0)
      begin n_errors++; $display("FAIL %s_idle: done=%b busy=%b out_valid=%b want 0 0 0", name, done, busy, out_valid); end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (a_ready !== 1'b0 || out_valid !== 1'b0 || out_row !== 2'd0 || busy !== 1'b0 || done !== 1'b0)
      begin n_errors++; $display("FAIL %s_flags: a_ready=%b out_valid=%b out_row=%0d busy=%b done=%b want all 0", name, a_ready, out_valid, out_row, busy, done); end
    n_checks++;
    if (out_data !== '0)
      begin n_errors++; $display("FAIL %s_data: got %h want 0", name, out_data); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    check_reset_values("reset");
  endtask

  task automatic test_identity();
    load_identity();
    run_job(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_after("identity");
  endtask

  // signed then unsigned, the second job started in the done cycle of the first
  task automatic test_back_to_back();
    load_const(8'hFF, 8'h02, 20'hFFFFE);
    run_job(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    load_const(8'hFF, 8'h02, 20'h001FE);
    run_job(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_after("back_to_back");
  endtask

  // 17 * 255 * 255 = 1105425 = 0x10DE11, which wraps to 0x0DE11
  task automatic test_wrap();
    load_const(8'hFF, 8'hFF, 20'h0DE11);
    run_job(17, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_after("wrap");
  endtask

  task automatic test_stalls();
    load_identity();
    run_job(4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_idle_after("stalls");
  endtask

  task automatic test_zero_len();
    load_const(8'hFF, 8'hFF, 20'h00000);
    run_job(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check_idle_after("zero_len");
  endtask

  task automatic test_reset_mid();
    load_identity();
    k_len = KW'(4);
    signed_mode = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      a_valid = 1'b1;
      for (int i = 0; i < N; i++) begin
        a_data[i*DW +: DW] = amat[i][b];
        b_data[i*DW +: DW] = bmat[b][i];
      end
      step();
    end
    a_valid = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_reset_values("reset_mid");
    run_job(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_idle_after("reset_mid");
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0;
    a_valid = 1'b0; a_data = '0; b_data = '0; out_ready = 1'b1;
    test_reset();
    test_identity();
    test_back_to_back();
    test_wrap();
    test_stalls();
    test_zero_len();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
